dma_arbiter: RTL

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dcpu_pkg.sv | 16 +
 rtl/rr_pick.sv | 30 +++
 rtl/dma_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dcpu_pkg.sv
// Shared types for the DMA-to-RAM port-b arbiter.
// Word/address typedefs and the arbiter FSM state encoding.
package dcpu_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr.
// A ptr of zero gives plain lowest-index-first priority.
module rr_pick
    import dcpu_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] gnt
);

    // Scan upward from ptr with wrap; the first set request wins.
    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NCH; off++) begin
            idx = IW'((int'(ptr) + off) % NCH);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_arbiter.sv
// Registered N-channel arbiter in front of RAM port b, with read steering.
// Define DMA_ARB_FIXED_PRI_EN for lowest-index priority without burst limit.
module dma_arbiter
    import dcpu_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4,
    parameter int RD_LAT    = 1
) (
    input  logic              DMA_CLOCK,
    input  logic              RESET,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    input  logic [NCH-1:0]    wren,
    output logic [NCH-1:0]    ack,
    output logic [NCH-1:0]    rvalid,
    output logic [DW-1:0]     rdata,
    output logic [AW-1:0]     RAM_addr,
    output logic [DW-1:0]     RAM_data,
    output logic              RAM_wren,
    input  logic [DW-1:0]     RAM_q
);

    localparam int IW = $clog2(NCH);

    arb_state_t     state;
    logic [IW-1:0]  owner;
    logic [NCH-1:0] pick;
    logic [IW-1:0]  pick_idx;
    logic [IW-1:0]  sel_idx;
    logic           keep;
    logic           burst_done;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_data;
    logic           sel_we;
    logic [NCH-1:0] tag_pipe [RD_LAT];

`ifdef DMA_ARB_FIXED_PRI_EN
    rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
        .req (req),
        .ptr ('0),
        .gnt (pick)
    );

    // Fixed priority: the owner only yields when it drops its request.
    always_comb begin
        burst_done = 1'b0;
    end
`else
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [IW-1:0]  ptr;
    logic [CW-1:0]  cnt;
    logic [NCH-1:0] own_oh;
    logic [NCH-1:0] others;

    rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick)
    );

    // Burst ends only if the limit is hit and someone else is waiting.
    always_comb begin
        own_oh     = NCH'(1) << owner;
        others     = req & ~own_oh;
        burst_done = (cnt == CW'(MAX_BURST)) && (|others);
    end
`endif

    // Decide whether the current owner keeps the port for another beat.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
        keep    = (state == GRANT) && req[owner] && !burst_done;
        sel_idx = keep ? owner : pick_idx;
    end

    // Mux the selected channel's beat onto the RAM side.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_we   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_addr = addr[i*AW +: AW];
                sel_data = wdata[i*DW +: DW];
                sel_we   = wren[i];
            end
        end
    end

    // Arbiter FSM: one beat per cycle whenever any request is present.
    always_ff @(posedge DMA_CLOCK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            owner    <= '0;
            ack      <= '0;
            RAM_addr <= '0;
            RAM_data <= '0;
            RAM_wren <= 1'b0;
`ifndef DMA_ARB_FIXED_PRI_EN
            ptr      <= '0;
            cnt      <= '0;
`endif
        end else if (|req) begin
            state    <= GRANT;
            owner    <= sel_idx;
            ack      <= NCH'(1) << sel_idx;
            RAM_addr <= sel_addr;
            RAM_data <= sel_data;
            RAM_wren <= sel_we;
`ifndef DMA_ARB_FIXED_PRI_EN
            ptr      <= (sel_idx == IW'(NCH - 1)) ? '0 : sel_idx + 1'b1;
            if (keep && (cnt != CW'(MAX_BURST)))
                cnt <= cnt + 1'b1;
            else
                cnt <= CW'(1);
`endif
        end else begin
            state    <= IDLE;
            ack      <= '0;
            RAM_wren <= 1'b0;
`ifndef DMA_ARB_FIXED_PRI_EN
            cnt      <= '0;
`endif
        end
    end

    // Read tags follow the RAM latency so data returns to the right channel.
    always_ff @(posedge DMA_CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int s = 0; s < RD_LAT; s++) tag_pipe[s] <= '0;
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            tag_pipe[0] <= RAM_wren ? '0 : ack;
            for (int s = 1; s < RD_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
            rvalid <= tag_pipe[RD_LAT-1];
            if (|tag_pipe[RD_LAT-1]) rdata <= RAM_q;
        end
    end

endmodule
